// File: rtl/can_pkg.sv
// Shared CAN frame field encodings and fixed field lengths for the decoder blocks.
package can_pkg;

  typedef enum logic [4:0] {
    INTEGRATE = 5'd0,
    IDLE      = 5'd1,
    ID_A      = 5'd2,
    SRR_RTR   = 5'd3,
    IDE       = 5'd4,
    ID_B      = 5'd5,
    RTR_EXT   = 5'd6,
    R1        = 5'd7,
    R0        = 5'd8,
    DLC       = 5'd9,
    DATA      = 5'd10,
    CRC       = 5'd11,
    CRC_DELIM = 5'd12,
    ACK_SLOT  = 5'd13,
    ACK_D     = 5'd14,
    EOF       = 5'd15,
    IFS       = 5'd16
  } field_t;

  localparam int ID_A_LEN = 11;
  localparam int ID_B_LEN = 18;
  localparam int DLC_LEN  = 4;
  localparam int CRC_LEN  = 15;

  // Counter load value for a field of the given length.
  function automatic logic [6:0] len_m1(input int len);
    return 7'(len - 1);
  endfunction

endpackage

// File: rtl/can_dlc_decoder.sv
// Maps (DLC, RTR) to the number of data-field bits, clamping DLC above MAX_BYTES.
module can_dlc_decoder #(
  parameter int MAX_BYTES = 8
) (
  input  logic [3:0] dlc,
  input  logic       rtr,
  output logic [6:0] data_bits
);

  localparam logic [3:0] CAP_DLC  = 4'(MAX_BYTES);
  localparam logic [6:0] CAP_BITS = 7'(MAX_BYTES * 8);

  always_comb begin
    data_bits = 7'd0;
    if (rtr)
      data_bits = 7'd0;
    else if (dlc > CAP_DLC)
      data_bits = CAP_BITS;
    else
      data_bits = {dlc, 3'b000};
  end

endmodule

// File: rtl/can_field_sequencer.sv
// Bit-level CAN frame sequencer: state/counter registers label the next bit to be sampled.
module can_field_sequencer
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int EOF_BITS  = 7,
  parameter int IFS_BITS  = 3,
  parameter int MAX_BYTES = 8
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       BIT_VALID,
  input  logic       ERROR_IN,
  output logic       F_CRC_D,
  output logic       F_ACK_SLOT,
  output logic       F_ACK_D,
  output logic       F_EOF,
  output logic       STUFF_EN,
  output logic [4:0] FIELD,
  output logic [6:0] BIT_CNT,
  output logic [3:0] DLC_OUT,
  output logic       IDE_OUT,
  output logic       RTR_OUT,
  output logic       FRAME_DONE
);

  localparam logic [6:0] IDLE_M1 = len_m1(IDLE_BITS);
  localparam logic [6:0] EOF_M1  = len_m1(EOF_BITS);
  localparam logic [6:0] IFS_M1  = len_m1(IFS_BITS);
  localparam logic [6:0] ID_A_M1 = len_m1(ID_A_LEN);
  localparam logic [6:0] ID_B_M1 = len_m1(ID_B_LEN);
  localparam logic [6:0] DLC_M1  = len_m1(DLC_LEN);
  localparam logic [6:0] CRC_M1  = len_m1(CRC_LEN);

  field_t     state_reg, state_next;
  logic [6:0] cnt_reg, cnt_next;
  logic [3:0] shift_reg, shift_next;
  logic [3:0] dlc_reg, dlc_next;
  logic       ide_reg, ide_next;
  logic       rtr_reg, rtr_next;
  logic       done_reg, done_next;

  logic       in_frame;
  logic       in_stuffed;
  logic       accept;
  logic [3:0] dlc_shifted;
  logic [6:0] data_bits;

  assign in_frame    = (state_reg != INTEGRATE) && (state_reg != IDLE);
  assign in_stuffed  = state_reg inside {ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0, DLC, DATA, CRC};
  assign accept      = BIT_VALID || !in_stuffed;
  assign dlc_shifted = {shift_reg[2:0], RX};

  // Length is decided from the DLC including the bit being sampled now.
  can_dlc_decoder #(
    .MAX_BYTES (MAX_BYTES)
  ) u_dlc_decoder (
    .dlc       (dlc_shifted),
    .rtr       (rtr_reg),
    .data_bits (data_bits)
  );

  always_ff @(posedge SP) begin
    if (reset) begin
      state_reg <= INTEGRATE;
      cnt_reg   <= IDLE_M1;
      shift_reg <= 4'd0;
      dlc_reg   <= 4'd0;
      ide_reg   <= 1'b0;
      rtr_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      dlc_reg   <= dlc_next;
      ide_reg   <= ide_next;
      rtr_reg   <= rtr_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    dlc_next   = dlc_reg;
    ide_next   = ide_reg;
    rtr_next   = rtr_reg;
    done_next  = 1'b0;

    if (in_frame && !ERROR_IN) begin
      state_next = INTEGRATE;
      cnt_next   = IDLE_M1;
    end else if (state_reg == INTEGRATE) begin
      if (!RX)
        cnt_next = IDLE_M1;
      else if (cnt_reg != 7'd0)
        cnt_next = cnt_reg - 7'd1;
      else begin
        state_next = IDLE;
        cnt_next   = 7'd0;
      end
    end else if (state_reg == IDLE) begin
      if (!RX) begin
        state_next = ID_A;
        cnt_next   = ID_A_M1;
      end
    end else if (state_reg == IFS && !RX && cnt_reg < IFS_M1) begin
      // Dominant after the first intermission bit is a new SOF.
      state_next = ID_A;
      cnt_next   = ID_A_M1;
    end else if (accept) begin
      if (state_reg == DLC)
        shift_next = dlc_shifted;
      if (cnt_reg != 7'd0) begin
        cnt_next = cnt_reg - 7'd1;
      end else begin
        cnt_next = 7'd0;
        case (state_reg)
          ID_A:    state_next = SRR_RTR;
          SRR_RTR: begin
            rtr_next   = RX;
            state_next = IDE;
          end
          IDE: begin
            ide_next = RX;
            if (RX) begin
              state_next = ID_B;
              cnt_next   = ID_B_M1;
            end else begin
              state_next = R0;
            end
          end
          ID_B:    state_next = RTR_EXT;
          RTR_EXT: begin
            rtr_next   = RX;
            state_next = R1;
          end
          R1:      state_next = R0;
          R0: begin
            state_next = DLC;
            cnt_next   = DLC_M1;
          end
          DLC: begin
            dlc_next = dlc_shifted;
            if (data_bits != 7'd0) begin
              state_next = DATA;
              cnt_next   = data_bits - 7'd1;
            end else begin
              state_next = CRC;
              cnt_next   = CRC_M1;
            end
          end
          DATA: begin
            state_next = CRC;
            cnt_next   = CRC_M1;
          end
          CRC:       state_next = CRC_DELIM;
          CRC_DELIM: state_next = ACK_SLOT;
          ACK_SLOT:  state_next = ACK_D;
          ACK_D: begin
            state_next = EOF;
            cnt_next   = EOF_M1;
          end
          EOF: begin
            state_next = IFS;
            cnt_next   = IFS_M1;
          end
          IFS: begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
          default: begin
            state_next = INTEGRATE;
            cnt_next   = IDLE_M1;
          end
        endcase
      end
    end
  end

  assign F_CRC_D    = (state_reg != CRC_DELIM);
  assign F_ACK_SLOT = (state_reg != ACK_SLOT);
  assign F_ACK_D    = (state_reg != ACK_D);
  assign F_EOF      = (state_reg != EOF);
  assign STUFF_EN   = in_stuffed;
  assign FIELD      = state_reg;
  assign BIT_CNT    = cnt_reg;
  assign DLC_OUT    = dlc_reg;
  assign IDE_OUT    = ide_reg;
  assign RTR_OUT    = rtr_reg;
  assign FRAME_DONE = done_reg;

endmodule

// File: tb/tb_can_field_sequencer.sv
// Directed-vector bench for can_field_sequencer; bit indices are counted from SOF = 0.
module tb_can_field_sequencer;
  import can_pkg::*;

  logic       SP = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1;
  logic       BIT_VALID = 1'b1;
  logic       ERROR_IN = 1'b1;
  logic       F_CRC_D, F_ACK_SLOT, F_ACK_D, F_EOF, STUFF_EN;
  logic [4:0] FIELD;
  logic [6:0] BIT_CNT;
  logic [3:0] DLC_OUT;
  logic       IDE_OUT, RTR_OUT, FRAME_DONE;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Each entry is {bit_valid, rx}.
  logic [1:0] q[$];
  logic [4:0] log_field[0:255];
  logic [6:0] log_cnt[0:255];
  int crcd_idx, crcd_cnt, acks_idx, ackd_idx, eof_cnt, done_idx, done_cnt, data_cnt;

  can_field_sequencer dut (
    .SP         (SP),
    .reset      (reset),
    .RX         (RX),
    .BIT_VALID  (BIT_VALID),
    .ERROR_IN   (ERROR_IN),
    .F_CRC_D    (F_CRC_D),
    .F_ACK_SLOT (F_ACK_SLOT),
    .F_ACK_D    (F_ACK_D),
    .F_EOF      (F_EOF),
    .STUFF_EN   (STUFF_EN),
    .FIELD      (FIELD),
    .BIT_CNT    (BIT_CNT),
    .DLC_OUT    (DLC_OUT),
    .IDE_OUT    (IDE_OUT),
    .RTR_OUT    (RTR_OUT),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 SP = ~SP;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic rx, input logic bv, input logic errn);
    RX = rx;
    BIT_VALID = bv;
    ERROR_IN = errn;
    @(posedge SP);
    #1;
    ERROR_IN = 1'b1;
    BIT_VALID = 1'b1;
  endtask

  task automatic integrate();
    for (int i = 0; i < 11; i++) send_bit(1'b1, 1'b1, 1'b1);
  endtask

  task automatic push(input logic b);
    q.push_back({1'b1, b});
  endtask

  task automatic build_frame(input logic ide_v, input logic [28:0] id, input logic rtr_v,
                             input logic [3:0] dlc_v, input int nbits);
    q.delete();
    push(1'b0);
    if (!ide_v) begin
      for (int k = 10; k >= 0; k--) push(id[k]);
      push(rtr_v);
      push(1'b0);
    end else begin
      for (int k = 28; k >= 18; k--) push(id[k]);
      push(1'b1);
      push(1'b1);
      for (int k = 17; k >= 0; k--) push(id[k]);
      push(rtr_v);
      push(1'b0);
    end
    push(1'b0);
    for (int k = 3; k >= 0; k--) push(dlc_v[k]);
    for (int k = 0; k < nbits; k++) push((k % 3) == 0);
    for (int k = 0; k < 15; k++) push(k[0]);
    push(1'b1);
    push(1'b0);
    push(1'b1);
    for (int k = 0; k < 10; k++) push(1'b1);
  endtask

  task automatic run_frame();
    crcd_idx = -1; crcd_cnt = 0; acks_idx = -1; ackd_idx = -1;
    eof_cnt = 0; done_idx = -1; done_cnt = 0; data_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      send_bit(q[i][0], q[i][1], 1'b1);
      log_field[i] = FIELD;
      log_cnt[i] = BIT_CNT;
      if (!F_CRC_D) begin crcd_cnt++; crcd_idx = i + 1; end
      if (!F_ACK_SLOT) acks_idx = i + 1;
      if (!F_ACK_D) ackd_idx = i + 1;
      if (!F_EOF) eof_cnt++;
      if (FRAME_DONE) begin done_cnt++; done_idx = i; end
      if (FIELD == DATA) data_cnt++;
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    @(posedge SP); #1;
    @(posedge SP); #1;
    check("rst_field", FIELD, INTEGRATE);
    check("rst_cnt", BIT_CNT, 10);
    check("rst_flags", {F_CRC_D, F_ACK_SLOT, F_ACK_D, F_EOF}, 4'hF);
    check("rst_stuff_en", STUFF_EN, 0);
    check("rst_done", FRAME_DONE, 0);
    check("rst_latches", {DLC_OUT, IDE_OUT, RTR_OUT}, 0);
    reset = 1'b0;

    // Integration, restarted by a dominant bit
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b1);
    check("int_cnt5", BIT_CNT, 5);
    send_bit(1'b0, 1'b1, 1'b1);
    check("int_restart_cnt", BIT_CNT, 10);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1, 1'b1);
    check("int_10_field", FIELD, INTEGRATE);
    check("int_10_cnt", BIT_CNT, 0);
    send_bit(1'b1, 1'b1, 1'b1);
    check("int_11_field", FIELD, IDLE);

    // Standard data frame, ID 0x123, DLC 2
    build_frame(1'b0, 29'h123, 1'b0, 4'd2, 16);
    run_frame();
    check("std_crcd_idx", crcd_idx, 50);
    check("std_crcd_cnt", crcd_cnt, 1);
    check("std_acks_idx", acks_idx, 51);
    check("std_ackd_idx", ackd_idx, 52);
    check("std_eof_cnt", eof_cnt, 7);
    check("std_done_idx", done_idx, 62);
    check("std_done_cnt", done_cnt, 1);
    check("std_data_bits", data_cnt, 16);
    check("std_dlc", DLC_OUT, 2);
    check("std_ide_rtr", {IDE_OUT, RTR_OUT}, 0);
    check("std_end_field", FIELD, IDLE);

    // Extended frame, DLC 0
    build_frame(1'b1, 29'h1234567, 1'b0, 4'd0, 0);
    run_frame();
    check("ext_crcd_idx", crcd_idx, 54);
    check("ext_data_bits", data_cnt, 0);
    check("ext_ide", IDE_OUT, 1);
    check("ext_done_cnt", done_cnt, 1);

    // Remote frame with DLC 8
    build_frame(1'b0, 29'h2AA, 1'b1, 4'd8, 0);
    run_frame();
    check("rtr_crcd_idx", crcd_idx, 34);
    check("rtr_data_bits", data_cnt, 0);
    check("rtr_dlc", DLC_OUT, 8);
    check("rtr_rtr", RTR_OUT, 1);

    // Data frame DLC 12 clamps to 64 data bits
    build_frame(1'b0, 29'h555, 1'b0, 4'd12, 64);
    run_frame();
    check("dlc12_data_bits", data_cnt, 64);
    check("dlc12_crcd_idx", crcd_idx, 98);
    check("dlc12_dlc", DLC_OUT, 12);
    check("dlc12_rtr", RTR_OUT, 0);

    // Stuff bits in ID_A and CRC, BIT_VALID low in ACK slot
    build_frame(1'b0, 29'h0F0, 1'b0, 4'd0, 0);
    q.insert(6, {1'b0, ~q[5][0]});
    q.insert(23, {1'b0, ~q[22][0]});
    q[37] = {1'b0, q[37][0]};
    run_frame();
    check("stuff_ida_cnt_pre", log_cnt[5], 5);
    check("stuff_ida_cnt_hold", log_cnt[6], 5);
    check("stuff_ida_field", log_field[6], ID_A);
    check("stuff_crc_cnt_pre", log_cnt[22], 11);
    check("stuff_crc_cnt_hold", log_cnt[23], 11);
    check("stuff_crc_field", log_field[23], CRC);
    check("stuff_crcd_idx", crcd_idx, 36);
    check("stuff_ackd_idx", ackd_idx, 38);
    check("stuff_done_idx", done_idx, 48);

    // Error during DATA
    build_frame(1'b0, 29'h123, 1'b0, 4'd2, 16);
    for (int i = 0; i < 22; i++) send_bit(q[i][0], q[i][1], 1'b1);
    check("err_pre_field", FIELD, DATA);
    send_bit(q[22][0], 1'b1, 1'b0);
    check("err_field", FIELD, INTEGRATE);
    check("err_cnt", BIT_CNT, 10);
    check("err_flags", {F_CRC_D, F_ACK_SLOT, F_ACK_D, F_EOF}, 4'hF);
    check("err_stuff_en", STUFF_EN, 0);
    check("err_dlc_hold", DLC_OUT, 2);
    integrate();
    check("err_reint_field", FIELD, IDLE);

    // Reset during CRC delimiter
    build_frame(1'b0, 29'h321, 1'b0, 4'd1, 8);
    for (int i = 0; i < 42; i++) send_bit(q[i][0], q[i][1], 1'b1);
    check("rstmid_crcd_pre", F_CRC_D, 0);
    reset = 1'b1;
    send_bit(1'b0, 1'b1, 1'b0);
    check("rstmid_crcd", F_CRC_D, 1);
    check("rstmid_field", FIELD, INTEGRATE);
    check("rstmid_dlc", DLC_OUT, 0);
    reset = 1'b0;
    integrate();

    // Dominant at the last IFS bit starts a new frame without FRAME_DONE
    build_frame(1'b0, 29'h0AB, 1'b0, 4'd0, 0);
    q[46] = 2'b10;
    run_frame();
    check("ifs_sof_field", FIELD, ID_A);
    check("ifs_sof_cnt", BIT_CNT, 10);
    check("ifs_sof_done_cnt", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
